// File: rtl/tty_writer.sv
// tty_writer: glass-TTY byte sink that writes 16-bit cells into the text buffer and tracks the cursor.
// Optional TTY_HW_SCROLL_EN: bottom-row LF scrolls by row copy; otherwise it wraps to row 0 and clears it.
module tty_writer #(
  parameter int unsigned ROWS = 32,
  parameter int unsigned COLS = 128
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic [8:0]  in_attr,
  output logic        in_ready,
  output logic        mem_en,
  output logic [7:0]  mem_we,
  output logic [19:0] mem_addr,
  output logic [63:0] mem_wrdata,
  input  logic [63:0] mem_rddata,
  output logic [6:0]  cursor_x,
  output logic [6:0]  cursor_y,
  output logic        busy
);

  localparam logic [6:0] MAX_X  = 7'(COLS - 1);
  localparam logic [6:0] MAX_Y  = 7'(ROWS - 1);
  localparam logic [5:0] LAST_R = 6'(ROWS - 1);
  localparam logic [4:0] LAST_W = 5'(COLS / 4 - 1);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
`ifdef TTY_HW_SCROLL_EN
    SCROLL_RD,
    SCROLL_WR,
`endif
    CLEAR
  } state_t;

`ifdef TTY_HW_SCROLL_EN
  localparam logic [5:0]  SCROLL_LAST = 6'(ROWS - 2);
  localparam state_t      LF_STATE    = SCROLL_RD;
  localparam logic [7:0]  LF_WE       = 8'h00;
  localparam logic [19:0] LF_ADDR     = 20'h80100;
  localparam logic [6:0]  LF_Y        = MAX_Y;
`else
  localparam state_t      LF_STATE    = CLEAR;
  localparam logic [7:0]  LF_WE       = 8'hFF;
  localparam logic [19:0] LF_ADDR     = 20'h80000;
  localparam logic [6:0]  LF_Y        = 7'd0;
`endif

  state_t      state;
  logic [5:0]  row;
  logic [4:0]  word;
  logic [5:0]  clr_end;
  logic [6:0]  fin_x;
  logic [6:0]  fin_y;
  logic [63:0] wr_q;

  function automatic logic [19:0] cell_addr(input logic [5:0] r, input logic [4:0] w);
    return {1'b1, 5'b0, r, w, 3'b000};
  endfunction

  assign in_ready = (state == IDLE) && !rst_i;
  assign busy     = (state != IDLE);

`ifdef TTY_HW_SCROLL_EN
  // Read data arrives in the SCROLL_WR cycle itself, so it is forwarded combinationally.
  assign mem_wrdata = (state == SCROLL_WR) ? mem_rddata : wr_q;
`else
  logic unused_rddata;
  assign unused_rddata = ^mem_rddata;
  assign mem_wrdata    = wr_q;
`endif

  // Memory strobes are registered: each transition loads the outputs for the next state's cycle.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= IDLE;
      cursor_x <= '0;
      cursor_y <= '0;
      fin_x    <= '0;
      fin_y    <= '0;
      row      <= '0;
      word     <= '0;
      clr_end  <= '0;
      wr_q     <= '0;
      mem_en   <= 1'b0;
      mem_we   <= '0;
      mem_addr <= '0;
    end else begin
      mem_en <= 1'b0;
      mem_we <= '0;
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            if (in_data >= 8'h20 && in_data <= 8'h7E) begin
              state    <= WRITE;
              mem_en   <= 1'b1;
              mem_we   <= 8'b0000_0011 << {cursor_x[1:0], 1'b0};
              mem_addr <= cell_addr(cursor_y[5:0], cursor_x[6:2]);
              wr_q     <= {4{in_attr, in_data[6:0]}};
            end else begin
              case (in_data)
                8'h0D: cursor_x <= '0;
                8'h08: if (cursor_x != '0) cursor_x <= cursor_x - 7'd1;
                8'h0A: begin
                  if (cursor_y < MAX_Y) begin
                    cursor_y <= cursor_y + 7'd1;
                  end else begin
                    state    <= LF_STATE;
                    mem_en   <= 1'b1;
                    mem_we   <= LF_WE;
                    mem_addr <= LF_ADDR;
                    row      <= '0;
                    word     <= '0;
                    clr_end  <= '0;
                    wr_q     <= '0;
                    fin_x    <= cursor_x;
                    fin_y    <= LF_Y;
                  end
                end
                8'h0C: begin
                  state    <= CLEAR;
                  mem_en   <= 1'b1;
                  mem_we   <= '1;
                  mem_addr <= cell_addr('0, '0);
                  row      <= '0;
                  word     <= '0;
                  clr_end  <= LAST_R;
                  wr_q     <= '0;
                  fin_x    <= '0;
                  fin_y    <= '0;
                end
                default: ;
              endcase
            end
          end
        end
        WRITE: begin
          if (cursor_x < MAX_X) begin
            cursor_x <= cursor_x + 7'd1;
            state    <= IDLE;
          end else if (cursor_y < MAX_Y) begin
            cursor_x <= '0;
            cursor_y <= cursor_y + 7'd1;
            state    <= IDLE;
          end else begin
            state    <= LF_STATE;
            mem_en   <= 1'b1;
            mem_we   <= LF_WE;
            mem_addr <= LF_ADDR;
            row      <= '0;
            word     <= '0;
            clr_end  <= '0;
            wr_q     <= '0;
            fin_x    <= '0;
            fin_y    <= LF_Y;
          end
        end
`ifdef TTY_HW_SCROLL_EN
        SCROLL_RD: begin
          state    <= SCROLL_WR;
          mem_en   <= 1'b1;
          mem_we   <= '1;
          mem_addr <= cell_addr(row, word);
        end
        SCROLL_WR: begin
          mem_en <= 1'b1;
          if (word == LAST_W) begin
            word <= '0;
            if (row == SCROLL_LAST) begin
              state    <= CLEAR;
              row      <= LAST_R;
              clr_end  <= LAST_R;
              mem_we   <= '1;
              mem_addr <= cell_addr(LAST_R, '0);
              wr_q     <= '0;
            end else begin
              state    <= SCROLL_RD;
              row      <= row + 6'd1;
              mem_addr <= cell_addr(row + 6'd2, '0);
            end
          end else begin
            state    <= SCROLL_RD;
            word     <= word + 5'd1;
            mem_addr <= cell_addr(row + 6'd1, word + 5'd1);
          end
        end
`endif
        CLEAR: begin
          if (word == LAST_W && row == clr_end) begin
            state    <= IDLE;
            cursor_x <= fin_x;
            cursor_y <= fin_y;
          end else begin
            mem_en <= 1'b1;
            mem_we <= '1;
            if (word == LAST_W) begin
              row      <= row + 6'd1;
              word     <= '0;
              mem_addr <= cell_addr(row + 6'd1, '0);
            end else begin
              word     <= word + 5'd1;
              mem_addr <= cell_addr(row, word + 5'd1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tty_writer.sv
// Scoreboard bench for tty_writer: expected memory strobes are queued by the stimulus and popped by a monitor.
`timescale 1ns/1ps
module tb_tty_writer;
  localparam int unsigned ROWS = 32;
  localparam int unsigned COLS = 128;
  localparam int unsigned WPR  = COLS / 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = '0;
  logic [8:0]  in_attr = '0;
  logic        in_ready;
  logic        mem_en;
  logic [7:0]  mem_we;
  logic [19:0] mem_addr;
  logic [63:0] mem_wrdata;
  logic [63:0] mem_rddata = '0;
  logic [6:0]  cursor_x;
  logic [6:0]  cursor_y;
  logic        busy;

  tty_writer #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid(in_valid), .in_data(in_data), .in_attr(in_attr),
    .in_ready(in_ready), .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wrdata(mem_wrdata), .mem_rddata(mem_rddata), .cursor_x(cursor_x), .cursor_y(cursor_y),
    .busy(busy)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [7:0]  we;
    logic [19:0] addr;
    logic [63:0] data;
  } op_t;

  op_t          exp_q[$];
  op_t          mon_e;
  logic [63:0]  model [int unsigned];
  logic [63:0]  wtmp;
  int           n_cmp = 0;
  int           n_err = 0;
  int unsigned  ex = 0;
  int unsigned  ey = 0;

  function automatic logic [19:0] addr_of(input int unsigned r, input int unsigned w);
    return 20'h80000 | 20'(r << 8) | 20'(w << 3);
  endfunction

  function automatic logic [63:0] pat(input int unsigned r, input int unsigned w);
    return {16'hC0DE, 8'(r), 8'(w), 16'h5A00 | 16'(w), 16'hA500 | 16'(r)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] we, input logic [19:0] addr, input logic [63:0] data);
    op_t e;
    e.we = we;
    e.addr = addr;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Monitor: every strobe must match the head of the expected queue.
  always @(negedge clk_i) begin
    if (mem_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_strobe: got addr %h we %h, want no strobe", mem_addr, mem_we);
      end else begin
        mon_e = exp_q.pop_front();
        check("strobe_addr", 64'(mem_addr), 64'(mon_e.addr));
        check("strobe_we", 64'(mem_we), 64'(mon_e.we));
        if (mon_e.we != 8'h00) check("strobe_data", mem_wrdata, mon_e.data);
      end
    end
  end

  // Text buffer model: byte-enabled writes, reads return data one cycle after the strobe.
  always @(posedge clk_i) begin
    if (mem_en === 1'b1 && mem_we == 8'h00) begin
      mem_rddata <= model.exists(int'(mem_addr[19:3])) ? model[int'(mem_addr[19:3])] : 64'h0;
    end else begin
      mem_rddata <= 64'hBAD0_BAD0_BAD0_BAD0;
      if (mem_en === 1'b1) begin
        wtmp = model.exists(int'(mem_addr[19:3])) ? model[int'(mem_addr[19:3])] : 64'h0;
        for (int i = 0; i < 8; i++) if (mem_we[i]) wtmp[8*i +: 8] = mem_wrdata[8*i +: 8];
        model[int'(mem_addr[19:3])] = wtmp;
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input logic [7:0] ch, input logic [8:0] at);
    int unsigned n;
    n = 0;
    @(negedge clk_i);
    in_valid = 1'b1;
    in_data  = ch;
    in_attr  = at;
    while (!in_ready && n < 5000) begin
      @(negedge clk_i);
      n++;
    end
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: got in_ready 0, want 1");
      in_valid = 1'b0;
    end else begin
      @(posedge clk_i);
      #1;
      in_valid = 1'b0;
      in_data  = 8'hFF;
      in_attr  = 9'h1FF;
    end
  endtask

  task automatic wait_idle(output int cnt);
    cnt = 0;
    while (busy === 1'b1 && cnt < 10000) begin
      tick();
      cnt++;
    end
    if (busy !== 1'b0) begin
      n_cmp++;
      n_err++;
      $display("FAIL idle_timeout: got busy %b, want 0", busy);
    end
  endtask

  // Printable character at the bench cursor (never used for a bottom-row wrap).
  task automatic put(input logic [7:0] ch, input logic [8:0] at);
    int c;
    push(8'(8'b11 << (2 * (ex % 4))), addr_of(ey, ex / 4), {4{at, ch[6:0]}});
    send(ch, at);
    wait_idle(c);
    if (ex == COLS - 1) begin
      ex = 0;
      ey = ey + 1;
    end else begin
      ex = ex + 1;
    end
  endtask

  task automatic check_cursor(input string name, input int unsigned x, input int unsigned y);
    check({name, "_x"}, 64'(cursor_x), 64'(x));
    check({name, "_y"}, 64'(cursor_y), 64'(y));
  endtask

  int cnt;

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_mem_en", 64'(mem_en), 64'd0);
    check("rst_mem_we", 64'(mem_we), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_mem_wrdata", mem_wrdata, 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check_cursor("rst_cursor", 0, 0);
    @(negedge clk_i);
    rst_i = 1'b0;
    tick();
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // 'A' with attr 0x1C0: cell 0xE041 in lane 0 of word 0x80000
    push(8'h03, 20'h80000, {4{16'hE041}});
    send(8'h41, 9'h1C0);
    check("write_cycle_in_ready", 64'(in_ready), 64'd0);
    check("write_cycle_busy", 64'(busy), 64'd1);
    tick();
    check("after_write_in_ready", 64'(in_ready), 64'd1);
    check_cursor("after_A", 1, 0);

    send(8'h08, 9'h0);
    check("bs_in_ready", 64'(in_ready), 64'd1);
    check_cursor("bs1", 0, 0);
    send(8'h08, 9'h0);
    check_cursor("bs_at_zero", 0, 0);
    send(8'h7F, 9'h0);
    send(8'h1B, 9'h0);
    send(8'h00, 9'h0);
    check("ignored_busy", 64'(busy), 64'd0);
    check_cursor("ignored", 0, 0);

    ex = 0;
    ey = 0;
    for (int i = 0; i < 5; i++) put(8'h61 + 8'(i), 9'(i));
    check_cursor("at5", 5, 0);
    push(8'h0C, 20'h80008, {4{16'h0042}});
    send(8'h42, 9'h000);
    wait_idle(cnt);
    check("print_busy_cycles", 64'(cnt), 64'd1);
    check_cursor("after_B", 6, 0);

    send(8'h0D, 9'h0);
    check_cursor("cr", 0, 0);
    ex = 0;
    for (int i = 0; i < COLS; i++) put(8'h21 + 8'(i % 90), 9'(i));
    check_cursor("row_wrap", 0, 1);

    send(8'h0A, 9'h0);
    check("lf_in_ready", 64'(in_ready), 64'd1);
    check_cursor("lf", 0, 2);
    for (int i = 0; i < ROWS - 3; i++) send(8'h0A, 9'h0);
    check_cursor("bottom", 0, ROWS - 1);
    ey = ROWS - 1;
    ex = 0;
    for (int i = 0; i < 3; i++) put(8'h5A, 9'h155);

`ifdef TTY_HW_SCROLL_EN
    for (int r = 0; r < ROWS; r++)
      for (int w = 0; w < WPR; w++) model[int'(addr_of(r, w) >> 3)] = pat(r, w);
    for (int r = 0; r < ROWS - 1; r++)
      for (int w = 0; w < WPR; w++) begin
        push(8'h00, addr_of(r + 1, w), 64'h0);
        push(8'hFF, addr_of(r, w), pat(r + 1, w));
      end
    for (int w = 0; w < WPR; w++) push(8'hFF, addr_of(ROWS - 1, w), 64'h0);
    send(8'h0A, 9'h0);
    wait_idle(cnt);
    check("scroll_busy_cycles", 64'(cnt), 64'd2016);
    check_cursor("after_scroll", 3, ROWS - 1);
`else
    for (int w = 0; w < WPR; w++) push(8'hFF, addr_of(0, w), 64'h0);
    send(8'h0A, 9'h0);
    wait_idle(cnt);
    check("wrap_clear_busy_cycles", 64'(cnt), 64'd32);
    check_cursor("after_wrap_clear", 3, 0);
`endif

    for (int r = 0; r < ROWS; r++)
      for (int w = 0; w < WPR; w++) push(8'hFF, addr_of(r, w), 64'h0);
    send(8'h0C, 9'h0);
    wait_idle(cnt);
    check("ff_busy_cycles", 64'(cnt), 64'd1024);
    check_cursor("after_ff", 0, 0);

    for (int i = 0; i < ROWS - 1; i++) send(8'h0A, 9'h0);
    check_cursor("bottom2", 0, ROWS - 1);
    // Whole screen is blank after the FF, so any copied word is zero.
`ifdef TTY_HW_SCROLL_EN
    for (int r = 0; r < ROWS - 1; r++)
      for (int w = 0; w < WPR; w++) begin
        push(8'h00, addr_of(r + 1, w), 64'h0);
        push(8'hFF, addr_of(r, w), 64'h0);
      end
    for (int w = 0; w < WPR; w++) push(8'hFF, addr_of(ROWS - 1, w), 64'h0);
`else
    for (int w = 0; w < WPR; w++) push(8'hFF, addr_of(0, w), 64'h0);
`endif
    send(8'h0A, 9'h0);
    repeat (20) tick();
    check("mid_op_busy", 64'(busy), 64'd1);
    @(negedge clk_i);
    rst_i = 1'b1;
    tick();
    check("mid_rst_mem_en", 64'(mem_en), 64'd0);
    check("mid_rst_in_ready", 64'(in_ready), 64'd0);
    check_cursor("mid_rst_cursor", 0, 0);
    exp_q.delete();
    @(negedge clk_i);
    rst_i = 1'b0;
    tick();
    check("mid_rst_release_ready", 64'(in_ready), 64'd1);
    push(8'h03, 20'h80000, {4{16'hE041}});
    send(8'h41, 9'h1C0);
    wait_idle(cnt);
    check_cursor("after_rst_A", 1, 0);

    repeat (4) tick();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
